// File: rtl/peak_interval_counter.sv
// Measures sample-tick intervals between accepted peaks and hands each one to the
// BPM stage over a valid/ready port, with refractory rejection and loss-of-sync timeout.
module peak_interval_counter #(
    parameter int unsigned WIDTH        = 6,
    parameter int unsigned FS           = 25,
    parameter int unsigned MIN_INTERVAL = 8,
    parameter int unsigned MAX_INTERVAL = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sample_tick,
    input  logic             peak_det,
    output logic [WIDTH-1:0] interval_count,
    output logic             interval_valid,
    input  logic             interval_ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             timeout
);

    // A zero MIN_INTERVAL would allow a zero interval to be published.
    if (FS == 0 || MIN_INTERVAL == 0 || MIN_INTERVAL > MAX_INTERVAL ||
        MAX_INTERVAL > 2**WIDTH - 1) begin : g_bad_params
        $error("peak_interval_counter: inconsistent parameters");
    end

    localparam logic [WIDTH:0] MIN_N = (WIDTH+1)'(MIN_INTERVAL);
    localparam logic [WIDTH:0] MAX_N = (WIDTH+1)'(MAX_INTERVAL);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH:0]   w_nxt;
    logic             w_pub;
    logic             w_to;

    logic [WIDTH-1:0] r_count;
    logic             r_valid;
    logic             r_overrun;
    logic             r_timeout;

    // One extra bit so the tick past MAX_INTERVAL is visible as an overflow.
    assign w_nxt = {1'b0, r_cnt} + (WIDTH+1)'(sample_tick);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pub       = 1'b0;
        w_to        = 1'b0;
        if (!en) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (peak_det) begin
                        w_state_nxt = COUNT;
                        w_cnt_nxt   = '0;
                    end
                end
                COUNT: begin
                    if (w_nxt > MAX_N) begin
                        w_to        = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = peak_det ? COUNT : IDLE;
                    end else if (peak_det && (w_nxt >= MIN_N)) begin
                        w_pub     = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = w_nxt[WIDTH-1:0];
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_to;

            // A publish coinciding with a transfer reloads and keeps valid high.
            if (w_pub) begin
                r_count <= w_nxt[WIDTH-1:0];
                r_valid <= 1'b1;
            end else if (r_valid && interval_ready) begin
                r_valid <= 1'b0;
            end

            if (w_pub && r_valid && !interval_ready) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign interval_count = r_count;
    assign interval_valid = r_valid;
    assign overrun        = r_overrun;
    assign timeout        = r_timeout;

endmodule

// File: tb/tb_peak_interval_counter.sv
// Directed scenarios followed by random traffic, every cycle compared against an
// integer-level model of the interval counting rules.
module tb_peak_interval_counter;

    localparam int WIDTH = 6;
    localparam int MINI  = 8;
    localparam int MAXI  = 63;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b1;
    logic             tick = 1'b0;
    logic             peak = 1'b0;
    logic             ready = 1'b1;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] interval_count;
    logic             interval_valid;
    logic             overrun;
    logic             timeout;

    int tests = 0;
    int fails = 0;

    bit m_armed;
    int m_ticks;
    int m_count;
    bit m_valid;
    bit m_ovr;
    bit m_to;

    always #5 clk = ~clk;

    peak_interval_counter #(
        .WIDTH       (WIDTH),
        .FS          (25),
        .MIN_INTERVAL(MINI),
        .MAX_INTERVAL(MAXI)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .sample_tick   (tick),
        .peak_det      (peak),
        .interval_count(interval_count),
        .interval_valid(interval_valid),
        .interval_ready(ready),
        .overrun       (overrun),
        .overrun_clr   (clr),
        .timeout       (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int t;
        bit pub;
        int pv;
        bit v_old;
        pub   = 1'b0;
        pv    = 0;
        v_old = m_valid;
        if (rst) begin
            m_armed = 1'b0; m_ticks = 0; m_count = 0;
            m_valid = 1'b0; m_ovr = 1'b0; m_to = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (!en) begin
            m_armed = 1'b0;
            m_ticks = 0;
        end else if (!m_armed) begin
            if (peak) begin
                m_armed = 1'b1;
                m_ticks = 0;
            end
        end else begin
            t = m_ticks + int'(tick);
            if (t > MAXI) begin
                m_to    = 1'b1;
                m_ticks = 0;
                m_armed = peak;
            end else if (peak && t >= MINI) begin
                pub     = 1'b1;
                pv      = t;
                m_ticks = 0;
            end else begin
                m_ticks = t;
            end
        end
        if (pub) begin
            m_count = pv;
            m_valid = 1'b1;
        end else if (v_old && ready) begin
            m_valid = 1'b0;
        end
        if (pub && v_old && !ready) m_ovr = 1'b1;
        else if (clr)              m_ovr = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("count",   32'(interval_count), 32'(m_count));
        chk("valid",   32'(interval_valid), 32'(m_valid));
        chk("overrun", 32'(overrun),        32'(m_ovr));
        chk("timeout", 32'(timeout),        32'(m_to));
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc();
        end
    endtask

    task automatic do_peak(input bit with_tick);
        peak = 1'b1; tick = with_tick; cyc();
        peak = 1'b0; tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1; cyc(); cyc();
        chk("rst_count", 32'(interval_count), 0);
        chk("rst_valid", 32'(interval_valid), 0);
        chk("rst_ovr",   32'(overrun),        0);
        chk("rst_to",    32'(timeout),        0);
        rst = 1'b0;

        // Three peaks 20 ticks apart
        do_peak(0);
        chk("s1_arm_valid", 32'(interval_valid), 0);
        for (int k = 0; k < 2; k++) begin
            do_ticks(20);
            do_peak(0);
            chk("s1_count", 32'(interval_count), 20);
            chk("s1_valid", 32'(interval_valid), 1);
            cyc();
            chk("s1_consumed", 32'(interval_valid), 0);
        end

        // Refractory rejection
        do_ticks(5);
        do_peak(0);
        chk("s2_ignored", 32'(interval_valid), 0);
        do_ticks(10);
        do_peak(0);
        chk("s2_count", 32'(interval_count), 15);
        chk("s2_valid", 32'(interval_valid), 1);

        // Timeout on the 64th tick, then a lone peak only arms
        do_ticks(63);
        chk("s3_no_to_yet", 32'(timeout), 0);
        tick = 1'b1; cyc(); tick = 1'b0;
        chk("s3_timeout", 32'(timeout), 1);
        cyc();
        chk("s3_pulse_end", 32'(timeout), 0);
        do_ticks(3);
        do_peak(0);
        chk("s3_arm_only", 32'(interval_valid), 0);

        // Overrun with ready low
        do_reset();
        ready = 1'b0;
        do_peak(0);
        do_ticks(10); do_peak(0);
        chk("s4_first", 32'(interval_count), 10);
        do_ticks(12); do_peak(0);
        chk("s4_count", 32'(interval_count), 12);
        chk("s4_valid", 32'(interval_valid), 1);
        chk("s4_ovr",   32'(overrun),        1);
        clr = 1'b1; cyc(); clr = 1'b0;
        chk("s4_clr", 32'(overrun), 0);
        chk("s4_held", 32'(interval_count), 12);
        ready = 1'b1; cyc();
        chk("s4_xfer", 32'(interval_valid), 0);

        // Coincident peak and tick
        do_reset();
        do_peak(0);
        do_ticks(9);
        do_peak(1);
        chk("s5_count", 32'(interval_count), 10);
        do_ticks(63);
        do_peak(1);
        chk("s5_timeout", 32'(timeout), 1);
        chk("s5_nopub",  32'(interval_valid), 0);
        do_ticks(11);
        do_peak(0);
        chk("s5_rearm", 32'(interval_count), 11);
        chk("s5_rearm_v", 32'(interval_valid), 1);

        // Enable drop with pending interval, then reset mid-count
        do_reset();
        ready = 1'b0;
        do_peak(0);
        do_ticks(10); do_peak(0);
        do_ticks(3);
        en = 1'b0; cyc(); cyc();
        chk("s6_pending", 32'(interval_valid), 1);
        chk("s6_pcount",  32'(interval_count), 10);
        ready = 1'b1; cyc();
        chk("s6_xfer", 32'(interval_valid), 0);
        en = 1'b1;
        do_ticks(2);
        do_peak(0);
        chk("s6_arm_only", 32'(interval_valid), 0);
        ready = 1'b0;
        do_ticks(9); do_peak(0);
        chk("s6_count9", 32'(interval_count), 9);
        do_ticks(3);
        do_reset();
        chk("s6_rst_count", 32'(interval_count), 0);
        chk("s6_rst_valid", 32'(interval_valid), 0);
        ready = 1'b1;

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            tick  = ($urandom_range(0, 1) == 1);
            peak  = ($urandom_range(0, 19) == 0);
            ready = ($urandom_range(0, 9) < 7);
            clr   = ($urandom_range(0, 19) == 0);
            en    = ($urandom_range(0, 49) != 0);
            rst   = ($urandom_range(0, 299) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
